// File: rtl/disp_chan_adapt.sv
`default_nettype none
// ============================================================================
// Module      : disp_chan_adapt
// Description : Colour-channel width adapter between a design's display
//               outputs and the TMDS encoder. Widens by bit replication,
//               narrows by truncation or 2x2 ordered dither. Two-stage
//               pipeline with sync/DE/frame delay-matched to colour.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_chan_adapt #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int DITHER  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_de,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_frame,
    input  logic [BPC_IN-1:0]  in_r,
    input  logic [BPC_IN-1:0]  in_g,
    input  logic [BPC_IN-1:0]  in_b,
    output logic               out_de,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_frame,
    output logic [BPC_OUT-1:0] out_r,
    output logic [BPC_OUT-1:0] out_g,
    output logic [BPC_OUT-1:0] out_b
);

    // Number of bits dropped when narrowing (0 otherwise).
    localparam int c_drop = (BPC_IN > BPC_OUT) ? (BPC_IN - BPC_OUT) : 0;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic              s1_de_q, s1_de_d;
    logic              s1_hs_q, s1_hs_d;
    logic              s1_vs_q, s1_vs_d;
    logic              s1_fr_q, s1_fr_d;
    logic [BPC_IN-1:0] s1_r_q, s1_r_d;
    logic [BPC_IN-1:0] s1_g_q, s1_g_d;
    logic [BPC_IN-1:0] s1_b_q, s1_b_d;
    logic              x_par_q, x_par_d;
    logic              y_par_q, y_par_d;

    // ------------------------------------------------------------------
    // Stage 2 (output) registers
    // ------------------------------------------------------------------
    logic               out_de_q, out_de_d;
    logic               out_hs_q, out_hs_d;
    logic               out_vs_q, out_vs_d;
    logic               out_fr_q, out_fr_d;
    logic [BPC_OUT-1:0] out_r_q, out_r_d;
    logic [BPC_OUT-1:0] out_g_q, out_g_d;
    logic [BPC_OUT-1:0] out_b_q, out_b_d;

    // Channel-indexed views of the stage-1 pixel and the adapted result.
    logic [2:0][BPC_IN-1:0]  w_px;
    logic [2:0][BPC_OUT-1:0] w_adapt;
    logic [1:0]              w_base;

    assign w_px[0] = s1_r_q;
    assign w_px[1] = s1_g_q;
    assign w_px[2] = s1_b_q;

    // Stage-1 next state: capture inputs and track pixel/line parity so that
    // x_par/y_par line up with the pixel currently held in stage 1.
    always_comb begin
        s1_de_d = in_de;
        s1_hs_d = in_hsync;
        s1_vs_d = in_vsync;
        s1_fr_d = in_frame;
        s1_r_d  = in_r;
        s1_g_d  = in_g;
        s1_b_d  = in_b;
        // Next stage-1 pixel continues the line: toggle; otherwise restart at 0.
        x_par_d = (s1_de_q && in_de) ? ~x_par_q : 1'b0;
        // Frame start wins over an end-of-line that happens on the same cycle.
        y_par_d = y_par_q;
        if (in_frame) begin
            y_par_d = 1'b0;
        end else if (s1_de_q && !in_de) begin
            y_par_d = ~y_par_q;
        end
    end

    // 2x2 ordered-dither base matrix, indexed by {y_par, x_par}.
    always_comb begin
        w_base = 2'd0;
        case ({y_par_q, x_par_q})
            2'b00:   w_base = 2'd0;
            2'b01:   w_base = 2'd2;
            2'b10:   w_base = 2'd3;
            2'b11:   w_base = 2'd1;
            default: w_base = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Width adaptation, selected at elaboration time
    // ------------------------------------------------------------------
    generate
        if (BPC_OUT > BPC_IN) begin : g_widen
            // Repeat the input MSB-first until the output is filled so that
            // zero stays zero and full scale becomes all ones.
            for (genvar ch = 0; ch < 3; ch++) begin : g_ch
                for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
                    assign w_adapt[ch][BPC_OUT-1-i] = w_px[ch][BPC_IN-1-(i % BPC_IN)];
                end
            end
            logic w_unused_par;
            assign w_unused_par = ^w_base;
        end else if (BPC_OUT == BPC_IN) begin : g_pass
            assign w_adapt = w_px;
            logic w_unused_par;
            assign w_unused_par = ^w_base;
        end else begin : g_narrow
            if (DITHER == 0) begin : g_trunc
                // Plain truncation: keep the top BPC_OUT bits.
                logic [2:0] w_unused_lo;
                for (genvar ch = 0; ch < 3; ch++) begin : g_ch
                    assign w_adapt[ch]     = w_px[ch][BPC_IN-1:c_drop];
                    assign w_unused_lo[ch] = ^w_px[ch][c_drop-1:0];
                end
                logic w_unused_par;
                assign w_unused_par = ^{w_base, w_unused_lo};
            end else begin : g_dither
                // Threshold scaled so its range sits just below one output LSB.
                logic [BPC_IN:0] w_thr;
                if (c_drop >= 2) begin : g_thr_shl
                    assign w_thr = (BPC_IN+1)'(w_base) << (c_drop - 2);
                end else begin : g_thr_shr
                    assign w_thr = (BPC_IN+1)'(w_base >> 1);
                end
                logic [2:0][BPC_IN:0] w_sum;
                logic [2:0]           w_unused_lo;
                for (genvar ch = 0; ch < 3; ch++) begin : g_ch
                    assign w_sum[ch]       = {1'b0, w_px[ch]} + w_thr;
                    // Carry out of BPC_IN bits means the result would wrap: clamp.
                    assign w_adapt[ch]     = w_sum[ch][BPC_IN] ? {BPC_OUT{1'b1}}
                                                               : w_sum[ch][BPC_IN-1:c_drop];
                    assign w_unused_lo[ch] = ^w_sum[ch][c_drop-1:0];
                end
            end
        end
    endgenerate

    // Stage-2 next state: delay controls, blank colour outside active video.
    always_comb begin
        out_de_d = s1_de_q;
        out_hs_d = s1_hs_q;
        out_vs_d = s1_vs_q;
        out_fr_d = s1_fr_q;
        out_r_d  = s1_de_q ? w_adapt[0] : '0;
        out_g_d  = s1_de_q ? w_adapt[1] : '0;
        out_b_d  = s1_de_q ? w_adapt[2] : '0;
    end

    // Pipeline registers; reset clears everything without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_de_q  <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_fr_q  <= 1'b0;
            s1_r_q   <= '0;
            s1_g_q   <= '0;
            s1_b_q   <= '0;
            x_par_q  <= 1'b0;
            y_par_q  <= 1'b0;
            out_de_q <= 1'b0;
            out_hs_q <= 1'b0;
            out_vs_q <= 1'b0;
            out_fr_q <= 1'b0;
            out_r_q  <= '0;
            out_g_q  <= '0;
            out_b_q  <= '0;
        end else begin
            s1_de_q  <= s1_de_d;
            s1_hs_q  <= s1_hs_d;
            s1_vs_q  <= s1_vs_d;
            s1_fr_q  <= s1_fr_d;
            s1_r_q   <= s1_r_d;
            s1_g_q   <= s1_g_d;
            s1_b_q   <= s1_b_d;
            x_par_q  <= x_par_d;
            y_par_q  <= y_par_d;
            out_de_q <= out_de_d;
            out_hs_q <= out_hs_d;
            out_vs_q <= out_vs_d;
            out_fr_q <= out_fr_d;
            out_r_q  <= out_r_d;
            out_g_q  <= out_g_d;
            out_b_q  <= out_b_d;
        end
    end

    assign out_de    = out_de_q;
    assign out_hsync = out_hs_q;
    assign out_vsync = out_vs_q;
    assign out_frame = out_fr_q;
    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_chan_adapt.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_chan_adapt
// Description : Directed self-checking bench for disp_chan_adapt covering
//               widen 5->8, truncate 8->5 and dither 8->5 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_chan_adapt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       de, hs, vs, fr;
    logic [4:0] r5, g5, b5;
    logic [7:0] r8, g8, b8;

    logic       w_de, w_hs, w_vs, w_fr;
    logic [7:0] w_r, w_g, w_b;
    logic       t_de, t_hs, t_vs, t_fr;
    logic [4:0] t_r, t_g, t_b;
    logic       d_de, d_hs, d_vs, d_fr;
    logic [4:0] d_r, d_g, d_b;

    int errors = 0;
    int checks = 0;

    logic [4:0] prev_r;
    logic       prev_de;
    logic       prev_hs, prev_vs, prev_fr;

    disp_chan_adapt #(.BPC_IN(5), .BPC_OUT(8), .DITHER(1)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_de(de), .in_hsync(hs), .in_vsync(vs),
        .in_frame(fr), .in_r(r5), .in_g(g5), .in_b(b5),
        .out_de(w_de), .out_hsync(w_hs), .out_vsync(w_vs), .out_frame(w_fr),
        .out_r(w_r), .out_g(w_g), .out_b(w_b)
    );

    disp_chan_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .in_de(de), .in_hsync(hs), .in_vsync(vs),
        .in_frame(fr), .in_r(r8), .in_g(g8), .in_b(b8),
        .out_de(t_de), .out_hsync(t_hs), .out_vsync(t_vs), .out_frame(t_fr),
        .out_r(t_r), .out_g(t_g), .out_b(t_b)
    );

    disp_chan_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(1)) u_dith (
        .clk(clk), .rst_n(rst_n), .in_de(de), .in_hsync(hs), .in_vsync(vs),
        .in_frame(fr), .in_r(r8), .in_g(g8), .in_b(b8),
        .out_de(d_de), .out_hsync(d_hs), .out_vsync(d_vs), .out_frame(d_fr),
        .out_r(d_r), .out_g(d_g), .out_b(d_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel to the dither instance; the output seen after the
    // edge is the one expected from the previous call.
    task automatic pix(input string tag, input logic d, input logic f,
                       input logic [7:0] r, input logic [4:0] e);
        de = d; fr = f; r8 = r;
        tick();
        check_eq({tag, "_r"}, d_r, prev_r);
        check_eq({tag, "_de"}, d_de, prev_de);
        prev_r  = e;
        prev_de = d;
    endtask

    initial begin
        rst_n = 1'b0;
        de = 0; hs = 0; vs = 0; fr = 0;
        r5 = 5'd7; g5 = 5'd7; b5 = 5'd7;
        r8 = 8'd99; g8 = 8'd99; b8 = 8'd99;

        // Reset state
        #12;
        check_eq("rst_w_r", w_r, 0);
        check_eq("rst_w_de", w_de, 0);
        check_eq("rst_t_r", t_r, 0);
        check_eq("rst_d_r", d_r, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Widen 5->8 and truncate 8->5, with latency
        de = 1;
        r5 = 5'b10110; g5 = 5'd31; b5 = 5'd0;
        r8 = 8'hFF; g8 = 8'h87; b8 = 8'h07;
        tick();
        check_eq("lat1_w_r", w_r, 0);
        check_eq("lat1_w_de", w_de, 0);
        tick();
        check_eq("wid_r", w_r, 181);
        check_eq("wid_g", w_g, 255);
        check_eq("wid_b", w_b, 0);
        check_eq("wid_de", w_de, 1);
        check_eq("trn_ff", t_r, 31);
        check_eq("trn_87", t_g, 16);
        check_eq("trn_07", t_b, 0);

        // Blanking with toggling syncs
        de = 0; r5 = 5'd31; g5 = 5'd31; b5 = 5'd31;
        for (int i = 0; i < 6; i++) begin
            hs = i[0]; vs = i[1]; fr = (i == 2);
            tick();
            if (i >= 1) begin
                check_eq("blk_hs", w_hs, prev_hs);
                check_eq("blk_vs", w_vs, prev_vs);
                check_eq("blk_fr", w_fr, prev_fr);
                check_eq("blk_de", w_de, 0);
                check_eq("blk_r", w_r, 0);
                check_eq("blk_g", w_g, 0);
            end
            prev_hs = hs; prev_vs = vs; prev_fr = fr;
        end
        hs = 0; vs = 0; fr = 0;

        // Ordered dither 8->5, constant 132, thresholds 0,4 / 6,2
        prev_r = 0; prev_de = 0;
        pix("fp",   0, 1, 8'd132, 0);
        pix("l0p0", 1, 0, 8'd132, 16);
        pix("l0p1", 1, 0, 8'd132, 17);
        pix("l0p2", 1, 0, 8'd132, 16);
        pix("l0p3", 1, 0, 8'd132, 17);
        pix("hb0",  0, 0, 8'd132, 0);
        pix("hb1",  0, 0, 8'd132, 0);
        pix("l1p0", 1, 0, 8'hFE,  31);
        pix("l1p1", 1, 0, 8'd132, 16);
        pix("l1p2", 1, 0, 8'd132, 17);
        pix("l1p3", 1, 0, 8'd132, 16);
        pix("hb2",  0, 0, 8'd132, 0);
        pix("l2p0", 1, 0, 8'd132, 16);
        pix("l2p1", 1, 0, 8'd132, 17);
        // Frame pulse on the same cycle as the line end: next line is row 0
        pix("fc",   0, 1, 8'd132, 0);
        pix("l3p0", 1, 0, 8'd132, 16);
        pix("l3p1", 1, 0, 8'd132, 17);
        pix("hb3",  0, 0, 8'd132, 0);
        pix("l4p0", 1, 0, 8'd132, 17);
        pix("l4p1", 1, 0, 8'd132, 16);

        // Asynchronous reset mid-line
        de = 1; r5 = 5'd31;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_d_r", d_r, 0);
        check_eq("arst_d_de", d_de, 0);
        check_eq("arst_w_r", w_r, 0);
        check_eq("arst_w_de", w_de, 0);
        check_eq("arst_t_r", t_r, 0);
        de = 0;
        tick();
        tick();
        rst_n = 1'b1;
        prev_r = 0; prev_de = 0;
        pix("rb",   0, 0, 8'd132, 0);
        pix("l5p0", 1, 0, 8'd132, 16);
        pix("l5p1", 1, 0, 8'd132, 17);
        pix("hb4",  0, 0, 8'd132, 0);
        pix("hb5",  0, 0, 8'd132, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
